// File: rtl/rf_op_sequencer_pkg.sv
// rtl/rf_op_sequencer_pkg.sv - shared encodings for the register-file command sequencer
package rf_seq_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_EXEC  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_ALU_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RSVD_OP     = 2'b10;

  // Bit 2 selects the {R3,R2} pair write in the register file.
  localparam logic [2:0] RF_WIDE_ADDR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_STORE_WAIT,
    ST_ALU_START,
    ST_ALU_WAIT,
    ST_WB
  } seq_state_t;

endpackage

// File: rtl/rf_op_sequencer_timeout.sv
// rtl/rf_op_sequencer_timeout.sv - ALU watchdog counter with clear, enable and expire
module seq_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expire marks the last permitted wait cycle, not the cycle after it.
  assign expire = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/rf_op_sequencer.sv
// rtl/rf_op_sequencer.sv - single-command sequencer owning the register file write port
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W   = 512,
  parameter int ALU_OP_W = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [1:0]            cmd_reg,
  input  logic [ALU_OP_W-1:0]   cmd_alu_op,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic [DATA_W-1:0]     st_data,
  input  logic [4*DATA_W-1:0]   rf_rd_data,
  output logic                  alu_start,
  output logic [ALU_OP_W-1:0]   alu_op,
  input  logic                  alu_done,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic                  rf_write,
  output logic [2:0]            rf_write_addr,
  output logic [2*DATA_W-1:0]   rf_write_data,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code
);

  seq_state_t state_q, state_d;

  logic                  live;
  logic                  accept;
  logic [1:0]            reg_q;
  logic [ALU_OP_W-1:0]   alu_op_q;
  logic                  wb_write_q;
  logic [2:0]            wb_addr_q;
  logic [2*DATA_W-1:0]   wb_data_q;
  logic                  rsvd_err_q;
  logic                  ctr_clear;
  logic                  ctr_en;
  logic                  tmo_expire;
  logic                  tmo_err;

  assign live   = !rst;
  assign accept = cmd_valid && cmd_ready;

  seq_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (ctr_clear),
    .enable(ctr_en),
    .expire(tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    ld_ready  = 1'b0;
    st_valid  = 1'b0;
    st_data   = '0;
    alu_start = 1'b0;
    alu_op    = '0;
    busy      = 1'b0;
    err       = 1'b0;
    err_code  = ERR_NONE;
    ctr_clear = 1'b0;
    ctr_en    = 1'b0;
    tmo_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = live;
        if (cmd_valid && live) begin
          case (cmd_op)
            OP_LOAD:  state_d = ST_LOAD_WAIT;
            OP_STORE: state_d = ST_STORE_WAIT;
            OP_EXEC:  state_d = ST_ALU_START;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_WAIT: begin
        ld_ready = live;
        if (ld_valid) state_d = ST_WB;
      end
      ST_STORE_WAIT: begin
        st_valid = live;
        if (live) st_data = rf_rd_data[reg_q*DATA_W +: DATA_W];
        if (st_ready) state_d = ST_IDLE;
      end
      ST_ALU_START: begin
        alu_start = live;
        if (live) alu_op = alu_op_q;
        ctr_clear = 1'b1;
        state_d   = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: begin
        if (live) alu_op = alu_op_q;
        ctr_en = 1'b1;
        // A done arriving on the final watchdog cycle still completes the op.
        if (alu_done) begin
          state_d = ST_WB;
        end else if (tmo_expire) begin
          state_d = ST_IDLE;
          tmo_err = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy = live && (state_q != ST_IDLE);
    if (live) begin
      if (tmo_err) begin
        err      = 1'b1;
        err_code = ERR_ALU_TIMEOUT;
      end else if (rsvd_err_q) begin
        err      = 1'b1;
        err_code = ERR_RSVD_OP;
      end
    end
  end

  // Write-back outputs are registered so WB presents them for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q      <= '0;
      alu_op_q   <= '0;
      wb_write_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rsvd_err_q <= 1'b0;
    end else begin
      wb_write_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rsvd_err_q <= accept && (cmd_op == OP_RSVD);
      if (accept && (cmd_op != OP_RSVD)) begin
        reg_q    <= cmd_reg;
        alu_op_q <= cmd_alu_op;
      end
      if ((state_q == ST_LOAD_WAIT) && ld_valid) begin
        wb_write_q <= 1'b1;
        wb_addr_q  <= {1'b0, reg_q};
        wb_data_q  <= {{DATA_W{1'b0}}, ld_data};
      end
      if ((state_q == ST_ALU_WAIT) && alu_done) begin
        wb_write_q <= 1'b1;
        wb_addr_q  <= RF_WIDE_ADDR;
        wb_data_q  <= alu_result;
      end
    end
  end

  // Reset drops a write that is already sitting in the WB registers.
  assign rf_write      = wb_write_q && live;
  assign rf_write_addr = live ? wb_addr_q : 3'b000;
  assign rf_write_data = live ? wb_data_q : '0;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb/tb_rf_op_sequencer.sv - scoreboard bench for rf_op_sequencer
module tb_rf_op_sequencer;

  localparam int DW  = 512;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [1:0]      cmd_reg;
  logic [1:0]      cmd_alu_op;
  logic            ld_valid;
  logic            ld_ready;
  logic [DW-1:0]   ld_data;
  logic            st_valid;
  logic            st_ready;
  logic [DW-1:0]   st_data;
  logic [4*DW-1:0] rf_rd_data;
  logic            alu_start;
  logic [1:0]      alu_op;
  logic            alu_done;
  logic [2*DW-1:0] alu_result;
  logic            rf_write;
  logic [2:0]      rf_write_addr;
  logic [2*DW-1:0] rf_write_data;
  logic            busy;
  logic            err;
  logic [1:0]      err_code;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]   model_regs [4];
  logic [DW-1:0]   rf_mem [4] = '{default: '0};
  logic [2:0]      wr_addr_q [$];
  logic [2*DW-1:0] wr_data_q [$];
  logic [DW-1:0]   st_q [$];
  logic [1:0]      alu_q [$];
  logic [1:0]      err_q [$];

  rf_op_sequencer #(.DATA_W(DW), .ALU_OP_W(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .cmd_alu_op(cmd_alu_op),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .rf_rd_data(rf_rd_data),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done), .alu_result(alu_result),
    .rf_write(rf_write), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Register file seen by the sequencer
  always @(posedge clk) begin
    if (rf_write) begin
      if (rf_write_addr[2]) begin
        rf_mem[2] <= rf_write_data[DW-1:0];
        rf_mem[3] <= rf_write_data[2*DW-1:DW];
      end else begin
        rf_mem[rf_write_addr[1:0]] <= rf_write_data[DW-1:0];
      end
    end
  end
  assign rf_rd_data = {rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]};

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act[127:0], exp[127:0]);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired", name);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: every DUT output event is matched against the scoreboard queues
  always @(negedge clk) begin
    if (rf_write) begin
      if (wr_addr_q.size() == 0) bound_fail("unexpected_rf_write");
      else begin
        check("wr_addr", 1024'(rf_write_addr), 1024'(wr_addr_q.pop_front()));
        check("wr_data", rf_write_data, wr_data_q.pop_front());
      end
    end else begin
      check("idle_write_bus", 1024'({rf_write_addr, rf_write_data != '0}), 1024'(0));
    end
    if (alu_start) begin
      if (alu_q.size() == 0) bound_fail("unexpected_alu_start");
      else check("alu_op", 1024'(alu_op), 1024'(alu_q.pop_front()));
    end
    if (st_valid && st_ready) begin
      if (st_q.size() == 0) bound_fail("unexpected_store");
      else check("store_data", 1024'(st_data), 1024'(st_q.pop_front()));
    end
    if (err) begin
      if (err_q.size() == 0) bound_fail("unexpected_err");
      else check("err_code", 1024'(err_code), 1024'(err_q.pop_front()));
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] r, input logic [1:0] aop);
    int n;
    cmd_op = op; cmd_reg = r; cmd_alu_op = aop; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin n++; @(negedge clk); end
    if (!cmd_ready) bound_fail("cmd_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_reg = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin n++; @(negedge clk); end
    if (busy) bound_fail("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic check_outputs(input logic exp_ready);
    check("o_cmd_ready", 1024'(cmd_ready), 1024'(exp_ready));
    check("o_misc", 1024'({busy, ld_ready, st_valid, alu_start, alu_op, rf_write, rf_write_addr, err, err_code}), 1024'(0));
    check("o_data", 1024'({st_data != '0, rf_write_data != '0}), 1024'(0));
  endtask

  task automatic do_load(input logic [1:0] r, input logic [DW-1:0] w, input int delay);
    int n;
    model_regs[r] = w;
    wr_addr_q.push_back({1'b0, r});
    wr_data_q.push_back({{DW{1'b0}}, w});
    send_cmd(2'b00, r, 2'($urandom));
    repeat (delay) begin @(posedge clk); #1; end
    ld_valid = 1'b1; ld_data = w;
    n = 0;
    @(negedge clk);
    while (!ld_ready && n < 20) begin n++; @(negedge clk); end
    if (!ld_ready) bound_fail("ld_ready");
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_data = rand_word();
    wait_idle();
  endtask

  task automatic do_store(input logic [1:0] r, input int stall);
    int n;
    st_q.push_back(model_regs[r]);
    send_cmd(2'b01, r, 2'($urandom));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("store_hold_valid", 1024'(st_valid), 1024'(1));
      check("store_hold_data", 1024'(st_data), 1024'(model_regs[r]));
      @(posedge clk); #1;
    end
    st_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!st_valid && n < 20) begin n++; @(negedge clk); end
    if (!st_valid) bound_fail("st_valid");
    @(posedge clk); #1;
    st_ready = 1'b0;
    wait_idle();
  endtask

  // d = cycles from alu_start to alu_done; 0 = never, > TMO = after the watchdog fired
  task automatic do_exec(input logic [1:0] aop, input int d);
    logic [DW-1:0] hi, lo;
    int n;
    alu_q.push_back(aop);
    if (d == 0 || d > TMO) err_q.push_back(2'b01);
    send_cmd(2'b10, 2'($urandom), aop);
    @(negedge clk);
    check("exec_start_latency", 1024'(alu_start), 1024'(1));
    if (d == 0) begin
      n = 0;
      do begin @(posedge clk); @(negedge clk); n++; end while (!err && n < 3 * TMO);
      check("timeout_cycle", 1024'(n), 1024'(TMO));
      check("timeout_ready_low", 1024'(cmd_ready), 1024'(0));
      @(negedge clk);
      check("timeout_ready_next", 1024'(cmd_ready), 1024'(1));
      @(posedge clk); #1;
    end else begin
      repeat (d) begin @(posedge clk); #1; end
      hi = rand_word(); lo = rand_word();
      if (d <= TMO) begin
        wr_addr_q.push_back(3'b100);
        wr_data_q.push_back({hi, lo});
        model_regs[2] = lo;
        model_regs[3] = hi;
      end
      alu_done = 1'b1; alu_result = {hi, lo};
      @(posedge clk); #1;
      alu_done = 1'b0;
      wait_idle();
    end
  endtask

  task automatic do_rsvd();
    err_q.push_back(2'b10);
    send_cmd(2'b11, 2'($urandom), 2'($urandom));
    @(negedge clk);
    check("rsvd_busy", 1024'(busy), 1024'(0));
    check("rsvd_ready", 1024'(cmd_ready), 1024'(1));
    @(posedge clk); #1;
    alu_done = 1'b1; alu_result = {rand_word(), rand_word()};
    @(posedge clk); #1;
    alu_done = 1'b0;
    @(negedge clk);
    check("idle_done_busy", 1024'(busy), 1024'(0));
    @(posedge clk); #1;
  endtask

  task automatic reset_in_alu_wait();
    alu_q.push_back(2'b01);
    send_cmd(2'b10, 2'b00, 2'b01);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check_outputs(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs(1'b1);
    @(posedge clk); #1;
  endtask

  task automatic reset_in_wb();
    alu_q.push_back(2'b10);
    send_cmd(2'b10, 2'b00, 2'b10);
    @(posedge clk); #1;
    alu_done = 1'b1; alu_result = {rand_word(), rand_word()};
    @(posedge clk); #1;
    alu_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("wb_reset_no_write", 1024'(rf_write), 1024'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs(1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int sel;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_alu_op = '0;
    ld_valid = 1'b0; ld_data = '0; st_ready = 1'b0; alu_done = 1'b0; alu_result = '0;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs(1'b1);
    @(posedge clk); #1;

    do_load(2'd2, 512'hA5, 3);
    do_load(2'd0, rand_word(), 0);
    do_load(2'd1, rand_word(), 1);
    do_load(2'd3, rand_word(), 2);
    do_store(2'd2, 0);
    do_exec(2'b01, 5);
    do_exec(2'b10, 0);
    do_exec(2'b11, TMO);
    do_store(2'd1, 4);
    do_store(2'd3, 0);
    do_store(2'd2, 1);
    do_load(2'd1, rand_word(), 0);
    do_store(2'd1, 0);
    do_rsvd();
    reset_in_alu_wait();
    reset_in_wb();

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      do_load(2'($urandom), rand_word(), $urandom_range(0, 3));
      else if (sel < 6) do_store(2'($urandom), $urandom_range(0, 3));
      else if (sel < 9) do_exec(2'($urandom), $urandom_range(1, TMO + 2));
      else              do_rsvd();
    end
    for (int r = 0; r < 4; r++) do_store(2'(r), 0);

    repeat (4) @(posedge clk);
    #1;
    check("wr_q_empty", 1024'(wr_addr_q.size()), 1024'(0));
    check("st_q_empty", 1024'(st_q.size()), 1024'(0));
    check("alu_q_empty", 1024'(alu_q.size()), 1024'(0));
    check("err_q_empty", 1024'(err_q.size()), 1024'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
